// File: rtl/tpu_pkg.sv
// Shared definitions for the C-buffer readback path.
//   - funct codes accepted on the command interface
//   - row geometry (index width, row width, word width)
//   - readback FSM state encoding
//   - row_word(): picks one 32-bit word out of a 128-bit row, word0 = MSBs
package tpu_pkg;

    localparam int ROW_BITS   = 16;
    localparam int ROW_WIDTH  = 128;
    localparam int WORD_WIDTH = 32;

    localparam logic [2:0] FUNCT_READ  = 3'd3;
    localparam logic [2:0] FUNCT_BURST = 3'd7;
    localparam logic [2:0] FUNCT_ABORT = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } rb_state_e;

    function automatic logic [WORD_WIDTH-1:0] row_word(
        input logic [ROW_WIDTH-1:0] row,
        input logic [1:0]           sel
    );
        logic [WORD_WIDTH-1:0] w;
        case (sel)
            2'd0:    w = row[127:96];
            2'd1:    w = row[95:64];
            2'd2:    w = row[63:32];
            default: w = row[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/c_readback_if.sv
// Command / response bus of the readback block.
//   cmd_valid/cmd_ready : command handshake, funct/input0/input1 qualify it
//   rsp_valid/rsp_ready : response handshake, rsp_data qualifies it
// master = command issuer / response consumer, slave = c_readback.
interface c_readback_if;
    import tpu_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            funct;
    logic [31:0]           input0;
    logic [31:0]           input1;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WORD_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, funct, input0, input1, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, funct, input0, input1, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/row_serializer.sv
// Selects the 32-bit response word out of the held row line.
//   row_line   : 128-bit row being returned (held by the owner while sending)
//   word_sel   : word index, 0 = [127:96] .. 3 = [31:0]
//   word_valid : response valid; output is forced to zero when low
//   word_out   : response word
// The owner keeps row_line and word_sel frozen while a word is stalled, so
// the output is stable for the whole stall without a separate register.
module row_serializer
    import tpu_pkg::*;
(
    input  logic [ROW_WIDTH-1:0]  row_line,
    input  logic [1:0]            word_sel,
    input  logic                  word_valid,
    output logic [WORD_WIDTH-1:0] word_out
);

    assign word_out = word_valid ? row_word(row_line, word_sel) : '0;

endmodule

// File: rtl/c_readback.sv
// C-buffer readback controller with a one-row cache.
//   clk, rst_n     : clock; synchronous reset, active HIGH despite the name
//   bus (slave)    : command handshake in, response word handshake out
//   buf_rd_en/idx  : C-buffer row read request, data returns next cycle
//   buf_rd_data    : C-buffer row
//   c_wr_en/idx    : C-buffer write snoop, invalidates a matching cached row
//   busy           : controller not idle
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// FETCH | buf_rd_en high for the current row
// WAIT  | buf_rd_data valid, captured into the cache line
// SEND  | rsp_valid high, presenting word word_q of the cached line
//
// ABORT is accepted in every state (cmd_ready tracks funct outside IDLE).
module c_readback
    import tpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    c_readback_if.slave          bus,
    output logic                 buf_rd_en,
    output logic [ROW_BITS-1:0]  buf_rd_idx,
    input  logic [ROW_WIDTH-1:0] buf_rd_data,
    input  logic                 c_wr_en,
    input  logic [ROW_BITS-1:0]  c_wr_idx,
    output logic                 busy
);

    rb_state_e             state_q, state_d;
    logic [ROW_WIDTH-1:0]  line_q, line_d;
    logic [ROW_BITS-1:0]   tag_q, tag_d;
    logic                  valid_q, valid_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [ROW_BITS-1:0]   rows_left_q, rows_left_d;
    logic [ROW_BITS-1:0]   rd_idx_q, rd_idx_d;
    logic [1:0]            word_q, word_d;
    logic                  burst_q, burst_d;

    logic                  cmd_fire;
    logic                  rsp_fire;
    logic                  is_abort;
    logic [ROW_BITS-1:0]   cmd_row;
    logic [ROW_BITS-1:0]   cmd_count;
    logic                  cache_hit;
    logic                  unused_cmd_bits;

    assign cmd_row   = bus.input0[ROW_BITS-1:0];
    assign cmd_count = bus.input1[ROW_BITS-1:0];
    assign unused_cmd_bits = ^{bus.input0[31:ROW_BITS], bus.input1[31:ROW_BITS]};

    assign is_abort      = (bus.funct == FUNCT_ABORT);
    assign bus.cmd_ready = (state_q == IDLE) || is_abort;
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    assign bus.rsp_valid = (state_q == SEND);
    assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;
    assign buf_rd_en     = (state_q == FETCH);
    assign buf_rd_idx    = rd_idx_q;
    assign busy          = (state_q != IDLE);

    // A snoop write to the requested row in the same cycle must not hit.
    assign cache_hit = valid_q && (tag_q == cmd_row) &&
                       !(c_wr_en && (c_wr_idx == cmd_row));

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        row_d       = row_q;
        rows_left_d = rows_left_q;
        rd_idx_d    = rd_idx_q;
        word_d      = word_q;
        burst_d     = burst_q;

        if (c_wr_en && (c_wr_idx == tag_q)) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (bus.funct == FUNCT_READ) begin
                        row_d       = cmd_row;
                        word_d      = bus.input1[1:0];
                        burst_d     = 1'b0;
                        rows_left_d = '0;
                        if (cache_hit) begin
                            state_d = SEND;
                        end else begin
                            rd_idx_d = cmd_row;
                            state_d  = FETCH;
                        end
                    end else if (bus.funct == FUNCT_BURST && cmd_count != '0) begin
                        row_d       = cmd_row;
                        rows_left_d = cmd_count;
                        word_d      = 2'd0;
                        burst_d     = 1'b1;
                        rd_idx_d    = cmd_row;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Line is always captured so the pending response uses it;
                // a snoop to this row only keeps it from becoming a hit later.
                line_d  = buf_rd_data;
                tag_d   = row_q;
                valid_d = !(c_wr_en && (c_wr_idx == row_q));
                state_d = SEND;
            end
            SEND: begin
                if (rsp_fire) begin
                    if (!burst_q) begin
                        state_d = IDLE;
                    end else if (word_q != 2'd3) begin
                        word_d = word_q + 2'd1;
                    end else if (rows_left_q == 16'd1) begin
                        rows_left_d = '0;
                        burst_d     = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        row_d       = row_q + 16'd1;
                        rd_idx_d    = row_q + 16'd1;
                        rows_left_d = rows_left_q - 16'd1;
                        word_d      = 2'd0;
                        state_d     = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cmd_fire && is_abort) begin
            state_d     = IDLE;
            valid_d     = 1'b0;
            rows_left_d = '0;
            word_d      = 2'd0;
            burst_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            line_q      <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
            row_q       <= '0;
            rows_left_q <= '0;
            rd_idx_q    <= '0;
            word_q      <= 2'd0;
            burst_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            row_q       <= row_d;
            rows_left_q <= rows_left_d;
            rd_idx_q    <= rd_idx_d;
            word_q      <= word_d;
            burst_q     <= burst_d;
        end
    end

    row_serializer u_ser (
        .row_line   (line_q),
        .word_sel   (word_q),
        .word_valid (bus.rsp_valid),
        .word_out   (bus.rsp_data)
    );

endmodule

// File: tb/tb_c_readback.sv
// Directed bench for c_readback: scoreboard of expected response words,
// C-buffer row model, cycle-exact checks on fetch/response timing.
module tb_c_readback;
    import tpu_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          buf_rd_en;
    logic [15:0]   buf_rd_idx;
    logic [127:0]  buf_rd_data = '0;
    logic          c_wr_en = 1'b0;
    logic [15:0]   c_wr_idx = '0;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    int            rd_count = 0;
    int            xfer_count = 0;
    logic [31:0]   exp_q[$];
    logic [127:0]  row7_val = 128'h70707070_71717171_72727272_73737373;
    bit            stall_prev = 1'b0;
    logic [31:0]   stall_data = '0;

    always #5 clk = ~clk;

    c_readback_if bus();

    c_readback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_idx  (buf_rd_idx),
        .buf_rd_data (buf_rd_data),
        .c_wr_en     (c_wr_en),
        .c_wr_idx    (c_wr_idx),
        .busy        (busy)
    );

    function automatic logic [127:0] mem_row(input logic [15:0] idx);
        if (idx == 16'd5) return 128'h11111111_22222222_33333333_44444444;
        if (idx == 16'd7) return row7_val;
        return {16'hA000, idx, 16'hB000, idx, 16'hC000, idx, 16'hD000, idx};
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] r, input int w);
        return r[127 - 32*w -: 32];
    endfunction

    // C-buffer model: row appears the cycle after the read request.
    always @(posedge clk) begin
        if (buf_rd_en === 1'b1) begin
            buf_rd_data <= mem_row(buf_rd_idx);
            rd_count    <= rd_count + 1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: mid-cycle sampling of the handshake.
    always @(negedge clk) begin
        if (stall_prev) begin
            check("hold_valid", bus.rsp_valid, 1'b1);
            check("hold_data", bus.rsp_data, stall_data);
        end
        stall_prev = 1'b0;
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1 && rst_n === 1'b0) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL rsp_unexpected obs=%0h exp=none", bus.rsp_data);
            end
            if (exp_q.size() != 0) check("rsp_data", bus.rsp_data, exp_q.pop_front());
            xfer_count++;
        end else if (bus.rsp_valid === 1'b1 && rst_n === 1'b0 &&
                     !(bus.cmd_valid === 1'b1 && bus.funct == FUNCT_ABORT)) begin
            stall_prev = 1'b1;
            stall_data = bus.rsp_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the accepting edge with the command withdrawn.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit done;
        done = 1'b0;
        bus.funct = f;
        bus.input0 = a;
        bus.input1 = b;
        bus.cmd_valid = 1'b1;
        #1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.cmd_ready === 1'b1) done = 1'b1;
            tick();
        end
        check("cmd_accept", done, 1'b1);
        bus.cmd_valid = 1'b0;
        bus.funct = 3'd0;
    endtask

    task automatic push_rows(input logic [15:0] start, input int n);
        logic [15:0] r;
        r = start;
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < 4; w++) exp_q.push_back(word_of(mem_row(r), w));
            r = r + 16'd1;
        end
    endtask

    task automatic wait_xfers(input int target);
        for (int i = 0; i < 200 && xfer_count < target; i++) tick();
        check("xfer_wait", xfer_count, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int base;
        logic [127:0] row7_new;

        bus.cmd_valid = 1'b0;
        bus.funct     = 3'd0;
        bus.input0    = '0;
        bus.input1    = '0;
        bus.rsp_ready = 1'b0;

        // Reset values
        rst_n = 1'b1;
        repeat (3) tick();
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, 32'h0);
        check("rst_buf_rd_en", buf_rd_en, 1'b0);
        check("rst_buf_rd_idx", buf_rd_idx, 16'h0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b0;
        tick();

        // Cold READ(5,2)
        bus.rsp_ready = 1'b1;
        rc0 = rd_count;
        exp_q.push_back(32'h33333333);
        issue(FUNCT_READ, 32'd5, 32'd2);
        check("cold_rd_en_t1", buf_rd_en, 1'b1);
        check("cold_rd_idx_t1", buf_rd_idx, 16'd5);
        check("cold_busy_t1", busy, 1'b1);
        check("cold_ready_t1", bus.cmd_ready, 1'b0);
        tick();
        check("cold_valid_t2", bus.rsp_valid, 1'b0);
        check("cold_rd_en_t2", buf_rd_en, 1'b0);
        tick();
        check("cold_valid_t3", bus.rsp_valid, 1'b1);
        tick();
        check("cold_idle_ready", bus.cmd_ready, 1'b1);
        check("cold_idle_busy", busy, 1'b0);
        check("cold_sb_empty", exp_q.size(), 0);
        check("cold_reads", rd_count - rc0, 1);
        check("cold_idx_hold", buf_rd_idx, 16'd5);

        // READ hit (5,0)
        rc0 = rd_count;
        exp_q.push_back(32'h11111111);
        issue(FUNCT_READ, 32'd5, 32'd0);
        check("hit_valid_t1", bus.rsp_valid, 1'b1);
        check("hit_rd_en_t1", buf_rd_en, 1'b0);
        tick();
        check("hit_sb_empty", exp_q.size(), 0);
        check("hit_reads", rd_count - rc0, 0);
        check("hit_ready", bus.cmd_ready, 1'b1);

        // BURST(0xFFFF,2) with 3 stall cycles per word
        bus.rsp_ready = 1'b0;
        rc0 = rd_count;
        base = xfer_count;
        push_rows(16'hFFFF, 2);
        issue(FUNCT_BURST, 32'h0000FFFF, 32'd2);
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < 20 && bus.rsp_valid !== 1'b1; i++) tick();
            check("burst_valid", bus.rsp_valid, 1'b1);
            check("burst_no_cmd", bus.cmd_ready, 1'b0);
            repeat (3) tick();
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
        check("burst_xfers", xfer_count - base, 8);
        check("burst_ready_after", bus.cmd_ready, 1'b1);
        check("burst_busy_after", busy, 1'b0);
        check("burst_sb_empty", exp_q.size(), 0);
        check("burst_reads", rd_count - rc0, 2);
        check("burst_idx_wrap", buf_rd_idx, 16'h0000);

        // Snoop invalidate of row 7
        bus.rsp_ready = 1'b1;
        exp_q.push_back(word_of(row7_val, 1));
        issue(FUNCT_READ, 32'd7, 32'd1);
        repeat (3) tick();
        check("snoop_first_done", exp_q.size(), 0);
        row7_new = 128'hDEAD0001_DEAD0002_DEAD0003_DEAD0004;
        row7_val = row7_new;
        c_wr_en = 1'b1;
        c_wr_idx = 16'd7;
        tick();
        c_wr_en = 1'b0;
        rc0 = rd_count;
        exp_q.push_back(32'hDEAD0004);
        issue(FUNCT_READ, 32'd7, 32'd3);
        check("snoop_refetch", buf_rd_en, 1'b1);
        repeat (3) tick();
        check("snoop_sb_empty", exp_q.size(), 0);
        check("snoop_reads", rd_count - rc0, 1);

        // Snoop during WAIT: response uses captured row, cache stays invalid
        exp_q.push_back(word_of(mem_row(16'd9), 0));
        issue(FUNCT_READ, 32'd9, 32'd0);
        tick();
        c_wr_en = 1'b1;
        c_wr_idx = 16'd9;
        tick();
        c_wr_en = 1'b0;
        tick();
        check("wait_snoop_sb", exp_q.size(), 0);
        exp_q.push_back(word_of(mem_row(16'd9), 2));
        issue(FUNCT_READ, 32'd9, 32'd2);
        check("wait_snoop_miss", buf_rd_en, 1'b1);
        repeat (3) tick();
        check("wait_snoop_sb2", exp_q.size(), 0);

        // ABORT mid-BURST(3,4) after 5 words
        base = xfer_count;
        push_rows(16'd3, 4);
        issue(FUNCT_BURST, 32'd3, 32'd4);
        wait_xfers(base + 5);
        bus.rsp_ready = 1'b0;
        bus.funct = FUNCT_ABORT;
        bus.cmd_valid = 1'b1;
        #1;
        check("abort_ready_busy", bus.cmd_ready, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.funct = 3'd0;
        check("abort_rsp_valid", bus.rsp_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_left", exp_q.size(), 11);
        exp_q.delete();
        bus.rsp_ready = 1'b1;
        rc0 = rd_count;
        repeat (4) tick();
        check("abort_no_reads", rd_count - rc0, 0);
        exp_q.push_back(word_of(mem_row(16'd4), 1));
        issue(FUNCT_READ, 32'd4, 32'd1);
        check("abort_cache_miss", buf_rd_en, 1'b1);
        repeat (3) tick();
        check("abort_sb_empty", exp_q.size(), 0);

        // Reset mid-BURST(3,4) after 2 words
        base = xfer_count;
        push_rows(16'd3, 4);
        issue(FUNCT_BURST, 32'd3, 32'd4);
        wait_xfers(base + 2);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b0;
        tick();
        check("rstb_rsp_valid", bus.rsp_valid, 1'b0);
        check("rstb_busy", busy, 1'b0);
        check("rstb_rd_en", buf_rd_en, 1'b0);
        check("rstb_rsp_data", bus.rsp_data, 32'h0);
        rst_n = 1'b0;
        check("rstb_left", exp_q.size(), 14);
        exp_q.delete();
        bus.rsp_ready = 1'b1;
        rc0 = rd_count;
        repeat (4) tick();
        check("rstb_no_reads", rd_count - rc0, 0);
        exp_q.push_back(word_of(mem_row(16'd3), 0));
        issue(FUNCT_READ, 32'd3, 32'd0);
        check("rstb_cache_miss", buf_rd_en, 1'b1);
        repeat (3) tick();
        check("rstb_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c_readback.md
C_READBACK -- requirements
Module: c_readback

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-high reset (asserted = 1).
REQ-003 SHALL have port funct, input, 3 bits: command code, sampled on accept.
REQ-004 SHALL have port input0, input, 32 bits: row index in [15:0].
REQ-005 SHALL have port input1, input, 32 bits: word select [1:0] (READ) or row count [15:0] (BURST).
REQ-006 SHALL have port cmd_valid / cmd_ready, input / output, 1 bit each: command handshake; accept = both high at posedge.
REQ-007 SHALL have port rsp_valid / rsp_ready, output / input, 1 bit each: response handshake; transfer = both high at posedge.
REQ-008 SHALL have port rsp_data, output, 32 bits: response word.
REQ-009 SHALL have port buf_rd_en / buf_rd_idx, output, 1 / 16 bits: C-buffer read request.
REQ-010 SHALL have port buf_rd_data, input, 128 bits: C-buffer row, valid the cycle after buf_rd_en.
REQ-011 SHALL have port c_wr_en / c_wr_idx, input, 1 / 16 bits: C-buffer write snoop.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL decode commands: READ = 3'd3, BURST = 3'd7, ABORT = 3'd4; any other funct accepted and ignored.
REQ-014 SHALL use states IDLE, FETCH, WAIT, SEND, with cmd_ready = 1 only in IDLE, except for ABORT (REQ-022).
REQ-015 SHALL map row words as word0 = [127:96], word1 = [95:64], word2 = [63:32], word3 = [31:0].
REQ-016 SHALL keep a one-row cache: a 128-bit line, a 16-bit tag and a valid bit.
REQ-017 SHALL handle a READ miss accepted at cycle T as follows: FETCH at T+1 with buf_rd_en = 1 and buf_rd_idx = row; WAIT at T+2 captures buf_rd_data into the cache; rsp_valid = 1 from T+3.
REQ-018 SHALL handle a READ hit (cache valid and tag = row) by going straight to SEND, with rsp_valid = 1 from T+1 and no buffer read.
REQ-019 SHALL handle BURST(row R, count N) by emitting 4N words (R word0..3, R+1 word0..3, ...), issuing one buffer read per row; row-index increment wraps 16'hFFFF to 16'h0000.
REQ-020 SHALL treat BURST with N = 0 as producing no response, returning to IDLE at T+1.
REQ-021 SHALL hold rsp_data and rsp_valid stable while rsp_valid = 1 and rsp_ready = 0; after the final word transfers, return to IDLE (cmd_ready = 1 next cycle).
REQ-022 SHALL accept ABORT in every state: next cycle go to IDLE, drop rsp_valid, clear the cache valid bit and discard any remaining burst words.
REQ-023 SHALL clear the cache valid bit when c_wr_en = 1 and c_wr_idx = tag.
REQ-024 SHALL, when a snoop write hits the row in WAIT, capture buf_rd_data but leave the cache invalid, so the current response still uses the captured data.
REQ-025 SHALL hold buf_rd_en = 0 outside FETCH, and buf_rd_idx SHALL hold its last value.

Reset
REQ-026 SHALL on rst_n = 1 force: state IDLE, cmd_ready 1, rsp_valid 0, rsp_data 0, buf_rd_en 0, buf_rd_idx 0, busy 0, cache valid 0, burst counters 0.
REQ-027 SHALL, on reset mid-burst, emit no further words and leave no pending buffer read.

Structure
REQ-028 SHALL place funct codes (READ/BURST/ABORT), ROW_BITS = 16, ROW_WIDTH = 128 and the state enum in shared package tpu_pkg.
REQ-029 SHALL put the 128-to-32 word selection and hold logic in sub-module row_serializer; the FSM, cache and counters stay in c_readback.

Verification
REQ-030 SHALL check a cold READ: row 5 holds 0x11111111_22222222_33333333_44444444, READ(5,2) -> buf_rd_en at T+1, rsp_data 0x33333333 valid at T+3.
REQ-031 SHALL check a READ hit: READ(5,0) right after the previous case -> no buf_rd_en, rsp_data 0x11111111 at T+1.
REQ-032 SHALL check BURST wrap with backpressure: BURST(0xFFFF,2) with rsp_ready low 3 cycles per word -> 8 words from row 0xFFFF then row 0x0000, data stable during stalls, cmd_ready back after the 8th transfer.
REQ-033 SHALL check snoop invalidate: after a READ of row 7, write c_wr_idx 7, then READ(7,3) -> new fetch issued, new data returned.
REQ-034 SHALL check abort and reset: ABORT mid-BURST(3,4) after 5 words, and separately rst_n high mid-burst -> rsp_valid 0 next cycle, busy 0, a following READ of row 3 misses.
